// File: rtl/aes_dec_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_dec_sequencer_if
// Groups every non-clock signal of the AES decryption sequencer.
//   Stream side  : key_valid, in_valid/in_ready/in_data/in_key_len,
//                  out_valid/out_ready/out_data/out_err
//   Datapath side: rk_addr -> rk_data (key store), dp_state/dp_final ->
//                  dp_result (shared inverse-round datapath)
// Modports:
//   master - the environment (stream source/sink, key store, datapath)
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface aes_dec_sequencer_if #(
    parameter int RK_AW = 4
);
    logic             key_valid;
    logic             in_valid;
    logic             in_ready;
    logic [0:127]     in_data;
    logic [1:0]       in_key_len;
    logic             out_valid;
    logic             out_ready;
    logic [0:127]     out_data;
    logic             out_err;
    logic [RK_AW-1:0] rk_addr;
    logic [0:127]     rk_data;
    logic [0:127]     dp_state;
    logic             dp_final;
    logic [0:127]     dp_result;

    modport master (
        output key_valid, in_valid, in_data, in_key_len, out_ready,
               rk_data, dp_result,
        input  in_ready, out_valid, out_data, out_err,
               rk_addr, dp_state, dp_final
    );

    modport slave (
        input  key_valid, in_valid, in_data, in_key_len, out_ready,
               rk_data, dp_result,
        output in_ready, out_valid, out_data, out_err,
               rk_addr, dp_state, dp_final
    );
endinterface

// File: rtl/aes_dec_sequencer.sv
// ---------------------------------------------------------------------------
// aes_dec_sequencer
// Iterative AES decryption controller. One block in flight: the state
// register is whitened with the last round key, then looped through an
// external combinational inverse-round datapath once per cycle, walking the
// round-key store from Nr-1 down to 0.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - aes_dec_sequencer_if.slave (stream + key-store/datapath signals)
// Latency accept -> out_valid: Nr+1 cycles (1 cycle for an illegal key length).
// ---------------------------------------------------------------------------
module aes_dec_sequencer #(
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14,
    parameter int RK_AW  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_dec_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [RK_AW-1:0] cnt_q, cnt_d;        // round-key index of the current round
    logic [RK_AW-1:0] nr_q, nr_d;          // round count of the block in flight
    logic [0:127]     data_q, data_d;      // AES state
    logic [0:127]     out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             accept;

    assign accept = bus.in_valid & bus.in_ready;

    // State register.
    // NOTE: every register, the 128-bit state included, is given a reset
    // value so an aborted block leaves nothing visible on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nr_q       <= '0;
            data_q     <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nr_q       <= nr_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: hold-by-default assignments keep this block latch-free.
        state_d    = state_q;
        cnt_d      = cnt_q;
        nr_d       = nr_q;
        data_d     = data_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = bus.in_data;
                    case (bus.in_key_len)
                        2'b00:   nr_d = RK_AW'(NR_128);
                        2'b01:   nr_d = RK_AW'(NR_192);
                        2'b10:   nr_d = RK_AW'(NR_256);
                        default: nr_d = '0;
                    endcase
                    if (bus.in_key_len == 2'b11) begin
                        // Illegal length: report immediately, no rounds run.
                        state_d    = DONE;
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                    end else begin
                        state_d    = INIT;
                        out_err_d  = 1'b0;
                    end
                end
            end
            INIT: begin
                // Initial AddRoundKey with round key Nr.
                data_d  = data_q ^ bus.rk_data;
                cnt_d   = nr_q - RK_AW'(1);
                state_d = ROUND;
            end
            ROUND: begin
                data_d = bus.dp_result;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    out_data_d = bus.dp_result;
                end else begin
                    cnt_d = cnt_q - RK_AW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        // rst_n gates in_ready so the stream sees no readiness while reset
        // is held, even though the FSM already sits in IDLE.
        bus.in_ready  = rst_n & bus.key_valid & (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = out_data_q;
        bus.out_err   = out_err_q;
        bus.rk_addr   = '0;
        bus.dp_state  = '0;
        bus.dp_final  = 1'b0;

        case (state_q)
            INIT: begin
                bus.rk_addr = nr_q;
            end
            ROUND: begin
                bus.rk_addr  = cnt_q;
                bus.dp_state = data_q;
                bus.dp_final = (cnt_q == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_sequencer
// Drives FIPS-197 known-answer ciphertexts through the sequencer. The bench
// supplies the environment: an expanded round-key store (key bytes 00,01,..)
// and a combinational inverse-round datapath. Plaintexts, latencies and
// round-key address sequences are fixed, hand-derived constants.
// ---------------------------------------------------------------------------
module tb_aes_dec_sequencer;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [127:0] rk_mem [0:15];

    aes_dec_sequencer_if #(.RK_AW(4)) bus ();

    aes_dec_sequencer #(
        .NR_128 (10),
        .NR_192 (12),
        .NR_256 (14),
        .RK_AW  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- GF(2^8) / AES reference helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    // InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (unless fin)
    function automatic logic [127:0] inv_round(input logic [127:0] st,
                                               input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        for (int k = 0; k < 16; k++) a[k] = st[127-8*k -: 8];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                b[w+4*c] = inv_sbox(a[w + 4*((c - w + 4) % 4)]) ^ rk[127-8*(w+4*c) -: 8];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c+0] = gmul(8'h0e,b[4*c]) ^ gmul(8'h0b,b[4*c+1]) ^ gmul(8'h0d,b[4*c+2]) ^ gmul(8'h09,b[4*c+3]);
                a[4*c+1] = gmul(8'h09,b[4*c]) ^ gmul(8'h0e,b[4*c+1]) ^ gmul(8'h0b,b[4*c+2]) ^ gmul(8'h0d,b[4*c+3]);
                a[4*c+2] = gmul(8'h0d,b[4*c]) ^ gmul(8'h09,b[4*c+1]) ^ gmul(8'h0e,b[4*c+2]) ^ gmul(8'h0b,b[4*c+3]);
                a[4*c+3] = gmul(8'h0b,b[4*c]) ^ gmul(8'h0d,b[4*c+1]) ^ gmul(8'h09,b[4*c+2]) ^ gmul(8'h0e,b[4*c+3]);
            end
            for (int k = 0; k < 16; k++) b[k] = a[k];
        end
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = b[k];
        return r;
    endfunction

    // Fill the round-key store for key 00 01 02 ... of the given length code.
    task automatic expand_keys(input logic [1:0] klen);
        int          nk;
        int          nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        nk   = (klen == 2'b00) ? 4 : (klen == 2'b01) ? 6 : 8;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 16; i++) rk_mem[i] = '0;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    assign bus.rk_data   = rk_mem[bus.rk_addr];
    assign bus.dp_result = inv_round(bus.dp_state, bus.rk_data, bus.dp_final);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_err"},   bus.out_err,   0);
        check({tag, "_out_data"},  bus.out_data,  0);
        check({tag, "_rk_addr"},   bus.rk_addr,   0);
        check({tag, "_dp_state"},  bus.dp_state,  0);
        check({tag, "_dp_final"},  bus.dp_final,  0);
    endtask

    // Offer one block, follow it through INIT/ROUND, check result and handshake.
    // hold = 0: out_ready high at DONE entry; otherwise stall for hold cycles.
    task automatic run_block(input string tag, input logic [127:0] ct,
                             input logic [1:0] klen, input int exp_lat, input int hold);
        int lat;
        bit got;
        int nr;
        nr = exp_lat - 1;
        expand_keys(klen);
        @(negedge clk);
        bus.out_ready  = (hold == 0);
        bus.in_valid   = 1'b1;
        bus.in_data    = ct;
        bus.in_key_len = klen;
        #1 check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i <= nr) begin
                check({tag, "_rk_addr"},  bus.rk_addr,  nr - i);
                check({tag, "_dp_final"}, bus.dp_final, (i == nr));
            end
            @(posedge clk);
            #1 lat++;
            if (bus.out_valid) got = 1'b1;
        end
        check({tag, "_latency"},  lat,          exp_lat);
        check({tag, "_out_data"}, bus.out_data, PT);
        check({tag, "_out_err"},  bus.out_err,  0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_data"},  bus.out_data,  PT);
            check({tag, "_hold_ready"}, bus.in_ready,  0);
        end
        if (hold != 0) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1 check({tag, "_hs_valid"}, bus.out_valid, 0);
        check({tag, "_hs_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.key_valid  = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_key_len = 2'b00;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < 16; i++) rk_mem[i] = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_block("k128", CT_128, 2'b00, 11, 0);
        run_block("k192", CT_192, 2'b01, 13, 0);
        run_block("k256", CT_256, 2'b10, 15, 5);
        run_block("b2b",  CT_128, 2'b00, 11, 0);

        // Illegal key length: DONE after one cycle with error and zero data.
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = CT_128;
        bus.in_key_len = 2'b11;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("illegal_valid", bus.out_valid, 1);
        check("illegal_err",   bus.out_err,   1);
        check("illegal_data",  bus.out_data,  0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check("illegal_hs", bus.out_valid, 0);

        // No key schedule: offered block must not be accepted.
        @(negedge clk);
        bus.key_valid  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_key_len = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1 check("nokey_ready", bus.in_ready, 0);
            @(posedge clk);
            #1 check("nokey_valid", bus.out_valid, 0);
            check("nokey_rk_addr", bus.rk_addr, 0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.key_valid = 1'b1;

        run_block("after_err", CT_192, 2'b01, 13, 0);

        // Reset during ROUND with round key 5 addressed.
        expand_keys(2'b00);
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = CT_128;
        bus.in_key_len = 2'b00;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rk_addr", bus.rk_addr, 5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        run_block("post_rst", CT_128, 2'b00, 11, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
